// File: rtl/vga_debug_scan.sv
// Debug-monitor VGA scan engine: 800x600@72Hz timing, row index to the line mapper,
// and serialisation of the latched 16-bit word into coloured bit cells per scanline.
module vga_debug_scan #(
  parameter int          H_VIS    = 800,
  parameter int          H_FP     = 56,
  parameter int          H_SYNC   = 120,
  parameter int          H_BP     = 64,
  parameter int          V_VIS    = 600,
  parameter int          V_FP     = 37,
  parameter int          V_SYNC   = 6,
  parameter int          V_BP     = 23,
  parameter int          X0       = 80,
  parameter int          CELL_W   = 40,
  parameter int          CELL_GAP = 4,
  parameter logic [7:0]  FG       = 8'hFC,
  parameter logic [7:0]  DIM      = 8'h24,
  parameter logic [7:0]  BG       = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        all,
  output logic [10:0] row_o,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb,
  output logic        frame_start
);

  localparam logic [10:0] H_LAST   = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS_L  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_L  = 11'(V_VIS);
  localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [10:0] X_PRE    = 11'(X0 - 1);
  localparam logic [10:0] X_FIRST  = 11'(X0);
  localparam logic [10:0] X_END    = 11'(X0 + 16 * CELL_W);
  localparam logic [5:0]  PX_LAST  = 6'(CELL_W - 1);
  localparam logic [5:0]  PX_GAP   = 6'(CELL_W - CELL_GAP);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] row_q, row_d;
  logic [15:0] data_q, data_d;
  logic        all_q, all_d;
  logic [3:0]  cell_idx_q, cell_idx_d;
  logic [5:0]  cell_px_q, cell_px_d;
  logic        cell_on_q, cell_on_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        visible;
  logic        in_cells;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end

    // Next line's row goes out at the start of hblank so the mapper has the whole blank to settle.
    row_d = row_q;
    if (h_cnt_q == H_VIS_L) begin
      row_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end

    data_d = data_q;
    all_d  = all_q;
    if (h_cnt_q == H_LAST) begin
      data_d = data;
      all_d  = all;
    end

    cell_on_d  = cell_on_q;
    cell_idx_d = cell_idx_q;
    cell_px_d  = cell_px_q;
    if (h_cnt_q == X_PRE) begin
      cell_on_d  = 1'b1;
      cell_idx_d = '0;
      cell_px_d  = '0;
    end else if (cell_on_q) begin
      if (cell_px_q == PX_LAST) begin
        cell_px_d = '0;
        if (cell_idx_q == 4'd15) begin
          cell_on_d = 1'b0;
        end else begin
          cell_idx_d = cell_idx_q + 4'd1;
        end
      end else begin
        cell_px_d = cell_px_q + 6'd1;
      end
    end

    visible  = (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
    in_cells = (h_cnt_q >= X_FIRST) && (h_cnt_q < X_END);

    rgb_d = BG;
    if (!visible) begin
      rgb_d = 8'h00;
    end else if (all_q || !in_cells || !cell_on_q) begin
      rgb_d = BG;
    end else if (cell_px_q >= PX_GAP) begin
      rgb_d = BG;
    end else begin
      rgb_d = data_q[4'd15 - cell_idx_q] ? FG : DIM;
    end

    hsync_d       = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    vsync_d       = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      row_q         <= '0;
      data_q        <= '0;
      all_q         <= 1'b1;
      cell_on_q     <= 1'b0;
      cell_idx_q    <= '0;
      cell_px_q     <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      rgb_q         <= BG;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      row_q         <= row_d;
      data_q        <= data_d;
      all_q         <= all_d;
      cell_on_q     <= cell_on_d;
      cell_idx_q    <= cell_idx_d;
      cell_px_q     <= cell_px_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_o       = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_debug_scan.sv
// Bench for vga_debug_scan: random mapper table, pixel-position reference model.
// Vertical geometry is shortened so a full frame plus a mid-run reset fits the cycle budget.
module tb_vga_debug_scan;

  localparam int H_T    = 1040;
  localparam int H_VIS  = 800;
  localparam int V_VIS  = 44;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int V_T    = V_VIS + V_FP + V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data;
  logic        all;
  logic [10:0] row_o;
  logic        hsync, vsync, frame_start;
  logic [7:0]  rgb;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int hs_cnt;
  int last_fs;

  logic [15:0] tbl_data [V_T];
  logic        tbl_all  [V_T];
  logic [15:0] exp_data [V_T];
  logic        exp_all  [V_T];

  always #10 clk = ~clk;

  vga_debug_scan #(
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .all(all), .row_o(row_o),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
  );

  // Line mapper: registered lookup, answer valid one clock after row_o.
  always @(posedge clk) begin
    data <= tbl_data[row_o];
    all  <= tbl_all[row_o];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(int h, int v);
    int k, idx;
    if (h >= H_VIS || v >= V_VIS) return 8'h00;
    if (exp_all[v]) return 8'h00;
    if (h < 80 || h >= 80 + 16 * 40) return 8'h00;
    k   = (h - 80) % 40;
    idx = (h - 80) / 40;
    if (k >= 36) return 8'h00;
    return exp_data[v][15 - idx] ? 8'hFC : 8'h24;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < V_T; r++) begin
      exp_data[r] = 16'h0000;
      exp_all[r]  = 1'b1;
    end
    n       = 0;
    hs_cnt  = 0;
    last_fs = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk(tag, {21'd0, row_o, hsync, vsync, frame_start, rgb}, 32'd0);
  endtask

  task automatic run(input int cycles, input bit allow_mutate);
    int ch, cv, ph, pv, l;
    logic [10:0] exp_row;
    logic [21:0] exp_vec;
    for (int c = 0; c < cycles && miscompares < 40; c++) begin
      @(posedge clk);
      n++;
      #1;
      ch = n % H_T;
      cv = (n / H_T) % V_T;
      ph = (n - 1) % H_T;
      pv = ((n - 1) / H_T) % V_T;
      exp_row = 11'((ch > 800) ? (cv + 1) % V_T : cv);
      exp_vec = {exp_row,
                 1'(ph >= 856 && ph <= 975),
                 1'(pv >= V_VIS + V_FP && pv <= V_VIS + V_FP + V_SYNC - 1),
                 1'(ph == 0 && pv == 0),
                 exp_pix(ph, pv)};
      chk($sformatf("scan L%0d X%0d", pv, ph),
          {10'd0, row_o, hsync, vsync, frame_start, rgb}, {10'd0, exp_vec});
      if (hsync) hs_cnt++;
      if (ph == H_T - 1) begin
        chk($sformatf("hsync_width L%0d", pv), 32'(hs_cnt), 32'd120);
        hs_cnt = 0;
      end
      if (frame_start) begin
        if (last_fs >= 0) chk("frame_period", 32'(n - last_fs), 32'(H_T * V_T));
        last_fs = n;
      end
      // The mapper answer for the row now on row_o is what gets latched two edges later.
      if (ch == H_T - 2) begin
        l = (cv + 1) % V_T;
        exp_data[l] = tbl_data[l];
        exp_all[l]  = tbl_all[l];
      end
      if (allow_mutate && ch == 300 && (n / H_T) == 20) begin
        tbl_data[20] = tbl_data[20] ^ 16'hFFFF;
        tbl_data[21] = 16'($urandom);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < V_T; r++) begin
      tbl_data[r] = 16'($urandom);
      tbl_all[r]  = (r >= V_VIS) ? 1'b1 : ($urandom_range(3) == 0);
    end
    tbl_data[30] = 16'hA5C3; tbl_all[30] = 1'b0;
    tbl_data[40] = 16'hFFFF; tbl_all[40] = 1'b1;
    tbl_all[20]  = 1'b0;
    tbl_all[21]  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_initial");
    @(negedge clk);
    reset = 1'b0;

    run(H_T * V_T + 2 * H_T + 500, 1'b1);

    // Asynchronous reset mid-line: outputs must clear before any clock edge.
    #5;
    reset = 1'b1;
    #1;
    check_reset_vals("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    run(12 * H_T, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
